nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Sequencing stage wrapped around the team's combinational 4-bit ripple adder (`fulladd`: `a[3:0]`, `b[3:0]`, `c`, `sum[3:0]`, `carry[3:0]`).
- Adds two wide operands one nibble per clock, least-significant nibble first. Drives `fulladd` operands upstream and captures its sum/carry downstream, chaining the carry between cycles.
- Gives wide additions without widening the adder. Start/busy/done handshake to the requester.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (default 16). Legal range 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only when busy=0
- op_a  in  W  operand A; sampled on accepted start
- op_b  in  W  operand B; sampled on accepted start
- cin  in  1  carry-in; sampled on accepted start
- busy  out  1  high while slices are being added
- done  out  1  one-cycle pulse when result is valid
- result  out  W  sum; held until the next accepted start
- cout  out  1  carry-out of the MSB slice
- ovf  out  1  two's-complement overflow flag
- add_a  out  4  to fulladd.a
- add_b  out  4  to fulladd.b
- add_c  out  1  to fulladd.c
- add_sum  in  4  from fulladd.sum
- add_carry  in  4  from fulladd.carry; only bit 3 (slice carry-out) is used

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, result, cout, ovf, add_a, add_b, add_c all 0; internal index, operand and carry registers 0.
- States:
  - IDLE: busy=0. If start=1, go to RUN next edge. On that edge, latch op_a, op_b, cin into the carry register and set idx=0.
  - RUN: busy=1.
    - Combinationally: add_a = a_reg[4*idx+:4], add_b = b_reg[4*idx+:4], add_c = carry_reg.
    - Each edge: result[4*idx+:4] <= add_sum; carry_reg <= add_carry[3]; idx <= idx+1.
    - On the edge where idx = NIBBLES-1, go to DONE. On that same edge: cout <= add_carry[3]; ovf <= (a_reg[W-1]==b_reg[W-1]) && (add_sum[3]!=a_reg[W-1]).
  - DONE: done=1 and busy=0 for exactly one cycle. A start here is accepted exactly as in IDLE (go to RUN); otherwise go to IDLE.
- add_a, add_b and add_c are 0 outside RUN.
- Latency:
  - start sampled at edge k; done high during the cycle after edge k+NIBBLES.
  - Throughput: one addition per NIBBLES+1 cycles with back-to-back starts.
- Register clearing:
  - result, cout and ovf are cleared when a start is accepted.
  - They are valid and stable from the DONE cycle until the next accepted start.
- start while busy=1: ignored, with no effect on the latched operands or the in-flight operation.
- Operand changes after acceptance: no effect; operands are latched.
- Reset mid-RUN: operation abandoned, all outputs zero immediately, no done pulse. The next start after reset release proceeds normally.
- Arithmetic: result + cout*2^W = op_a + op_b + cin, exact (mod 2^(W+1)).

Test Plan:
1. Assert rst for 2 cycles, then release -> busy, done, result, cout, ovf, add_a, add_b, add_c all 0; idle with start=0 -> no change.
2. op_a=0x1234, op_b=0x4321, cin=0, start pulse -> busy for 4 cycles; add_a sequence 4,3,2,1 and add_b 1,2,3,4; done on cycle 5 with result=0x5555, cout=0, ovf=0.
3. op_a=0xFFFF, op_b=0x0001, cin=0 -> add_c = 0,1,1,1 across slices; result=0x0000, cout=1, ovf=0.
4. op_a=0x7FFF, op_b=0x0000, cin=1 -> result=0x8000, cout=0, ovf=1.
5. Start op 0x000F+0x0001, pulse start again with 0xAAAA operands mid-RUN -> ignored, result=0x0010. Then a start in the done cycle with 0x0001+0x0002 -> accepted, result=0x0003 after 5 more cycles.
6. Start 0x1111+0x2222, assert rst during slice 2 -> outputs 0 at once, no done pulse. After release, start 0x0F0F+0x00F1 -> result=0x1000, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: feeds one nibble per clock to an external 4-bit ripple adder
// (fulladd), least-significant slice first, chaining the slice carry between cycles.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c,
    input  logic [3:0]           add_sum,
    input  logic [3:0]           add_carry
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: like-signed operands producing a differently-signed sum.
    function automatic logic sum_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    a_sh_r;
    logic [W-1:0]    b_sh_r;
    logic            a_msb_r;
    logic            b_msb_r;
    logic [W-1:0]    result_r;
    logic            cout_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;
    logic [3:0]      add_a_r;
    logic [3:0]      add_b_r;
    logic            add_c_r;
    logic            accept_s;
    logic            unused_carry_s;

    // A start is honoured whenever no slices are in flight (IDLE or DONE).
    assign accept_s = start && (state_r != RUN);

    // Only the slice carry-out of the external adder is consumed.
    assign unused_carry_s = ^add_carry[2:0];

    // Sequencer: the adder operand registers are loaded one cycle ahead so that
    // add_a/add_b/add_c already present the slice being summed in each RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            add_a_r  <= 4'h0;
            add_b_r  <= 4'h0;
            add_c_r  <= 1'b0;
        end else if (accept_s) begin
            state_r  <= RUN;
            idx_r    <= '0;
            a_sh_r   <= op_a;
            b_sh_r   <= op_b;
            a_msb_r  <= op_a[W-1];
            b_msb_r  <= op_b[W-1];
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            add_a_r  <= op_a[3:0];
            add_b_r  <= op_b[3:0];
            add_c_r  <= cin;
        end else begin
            case (state_r)
                RUN: begin
                    result_r[{idx_r, 2'b00} +: 4] <= add_sum;
                    a_sh_r <= a_sh_r >> 4'd4;
                    b_sh_r <= b_sh_r >> 4'd4;
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        cout_r  <= add_carry[3];
                        ovf_r   <= sum_overflow(a_msb_r, b_msb_r, add_sum[3]);
                        add_a_r <= 4'h0;
                        add_b_r <= 4'h0;
                        add_c_r <= 1'b0;
                    end else begin
                        state_r <= RUN;
                        idx_r   <= idx_r + IW'(1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        add_a_r <= a_sh_r[7:4];
                        add_b_r <= b_sh_r[7:4];
                        add_c_r <= add_carry[3];
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                IDLE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    add_a_r <= 4'h0;
                    add_b_r <= 4'h0;
                    add_c_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;
    assign add_a  = add_a_r;
    assign add_b  = add_b_r;
    assign add_c  = add_c_r;

endmodule
